// File: rtl/cache_mem_bridge.sv
// Cache miss responder: turns line/word read and write transactions into single-word
// SRAM-style accesses. Optional feature macro: CACHE_BRIDGE_WBUF_FWD_EN (line read forwarding).
module cache_mem_bridge #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [2:0]           rd_type,
  input  logic [31:0]          rd_addr,
  output logic                 rd_rdy,
  output logic                 ret_valid,
  output logic                 ret_last,
  output logic [31:0]          ret_data,
  input  logic                 wr_req,
  input  logic [2:0]           wr_type,
  input  logic [31:0]          wr_addr,
  input  logic [3:0]           wr_wstrb,
  input  logic [WIDTH*8-1:0]   wr_data,
  output logic                 wr_rdy,
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [1:0]           mem_size,
  output logic [31:0]          mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_addr_ok,
  input  logic                 mem_data_ok,
  input  logic [31:0]          mem_rdata
);
  localparam int WORDS = WIDTH / 4;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LB    = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rdy_en_q;
  logic                 rd_pend_q, rd_pend_d;
  logic                 rd_line_q, rd_line_d;
  logic [1:0]           rd_size_q, rd_size_d;
  logic [31:0]          rd_addr_q, rd_addr_d;
  logic                 wb_full_q, wb_full_d;
  logic                 wb_line_q, wb_line_d;
  logic [31:0]          wb_addr_q, wb_addr_d;
  logic [3:0]           wb_wstrb_q, wb_wstrb_d;
  logic [WIDTH*8-1:0]   wb_data_q, wb_data_d;
  logic                 rd_free, wb_free, same_line, burst_last, fwd_active;
  logic [31:0]          rd_word_addr, wb_word_addr;
`ifdef CACHE_BRIDGE_WBUF_FWD_EN
  logic [CW-1:0]        fwd_cnt_q, fwd_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_pend_d  = rd_pend_q;
    rd_line_d  = rd_line_q;
    rd_size_d  = rd_size_q;
    rd_addr_d  = rd_addr_q;
    wb_full_d  = wb_full_q;
    wb_line_d  = wb_line_q;
    wb_addr_d  = wb_addr_q;
    wb_wstrb_d = wb_wstrb_q;
    wb_data_d  = wb_data_q;
    rd_free    = 1'b0;
    wb_free    = 1'b0;
    ret_valid  = 1'b0;
    ret_last   = 1'b0;
    ret_data   = '0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_size   = 2'd0;
    mem_addr   = '0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    burst_last   = (cnt_q == CW'(WORDS - 1));
    rd_word_addr = rd_line_q ? {rd_addr_q[31:LB], cnt_q, 2'b00} : rd_addr_q;
    wb_word_addr = wb_line_q ? {wb_addr_q[31:LB], cnt_q, 2'b00} : wb_addr_q;
    same_line    = wb_full_q && (rd_addr_q[31:LB] == wb_addr_q[31:LB]);
`ifdef CACHE_BRIDGE_WBUF_FWD_EN
    // Once started, forwarding continues from the held buffer even if the drain frees it.
    fwd_cnt_d  = fwd_cnt_q;
    fwd_active = rd_pend_q && rd_line_q && ((fwd_cnt_q != '0) || same_line);
    if (fwd_active) begin
      ret_valid = 1'b1;
      ret_data  = wb_data_q[{fwd_cnt_q, 5'b00000} +: 32];
      fwd_cnt_d = fwd_cnt_q + 1'b1;
      if (fwd_cnt_q == CW'(WORDS - 1)) begin
        ret_last = 1'b1;
        rd_free  = 1'b1;
      end
    end
`else
    fwd_active = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (rd_pend_q && !same_line && !fwd_active) state_d = RD_ADDR;
        else if (wb_full_q)                          state_d = WR_ADDR;
      end
      RD_ADDR: begin
        mem_req  = 1'b1;
        mem_size = rd_line_q ? 2'd2 : rd_size_q;
        mem_addr = rd_word_addr;
        if (mem_addr_ok) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (mem_data_ok) begin
          ret_valid = 1'b1;
          ret_data  = mem_rdata;
          if (!rd_line_q || burst_last) begin
            ret_last = 1'b1;
            rd_free  = 1'b1;
            cnt_d    = '0;
            state_d  = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = wb_word_addr;
        mem_wstrb = wb_wstrb_q;
        mem_wdata = wb_line_q ? wb_data_q[{cnt_q, 5'b00000} +: 32] : wb_data_q[31:0];
        if (mem_addr_ok) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (mem_data_ok) begin
          if (!wb_line_q || burst_last) begin
            wb_free = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = WR_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rd_rdy = rdy_en_q && !rd_pend_q;
    wr_rdy = rdy_en_q && !wb_full_q && !fwd_active;
    if (rd_free) rd_pend_d = 1'b0;
    if (wb_free) wb_full_d = 1'b0;
    if (rd_req && rd_rdy) begin
      rd_pend_d = 1'b1;
      rd_line_d = (rd_type == 3'b100);
      rd_size_d = rd_type[1:0];
      rd_addr_d = rd_addr;
    end
    if (wr_req && wr_rdy) begin
      wb_full_d  = 1'b1;
      wb_line_d  = (wr_type == 3'b100);
      wb_addr_d  = wr_addr;
      wb_wstrb_d = (wr_type == 3'b100) ? 4'hF : wr_wstrb;
      wb_data_d  = wr_data;
    end

    // Outputs go quiet in the reset cycle itself, not only after the clock edge.
    if (reset) begin
      ret_valid = 1'b0;
      ret_last  = 1'b0;
      ret_data  = '0;
      mem_req   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdy_en_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      wb_full_q <= 1'b0;
`ifdef CACHE_BRIDGE_WBUF_FWD_EN
      fwd_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdy_en_q  <= 1'b1;
      rd_pend_q <= rd_pend_d;
      wb_full_q <= wb_full_d;
`ifdef CACHE_BRIDGE_WBUF_FWD_EN
      fwd_cnt_q <= fwd_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    rd_line_q  <= rd_line_d;
    rd_size_q  <= rd_size_d;
    rd_addr_q  <= rd_addr_d;
    wb_line_q  <= wb_line_d;
    wb_addr_q  <= wb_addr_d;
    wb_wstrb_q <= wb_wstrb_d;
    wb_data_q  <= wb_data_d;
  end
endmodule
